// File: rtl/universal_modulo_counter.sv
// Programmable-modulus up/down counter with wrap/saturate modes and registered boundary pulses.
// Optional prescaler on the count enable is compiled in when UMC_PRESCALE_EN is defined.
module universal_modulo_counter #(
  parameter int WIDTH    = 8,
  parameter int STEP_W   = 4,
  parameter int PRESCALE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              up,
  input  logic              sat,
  input  logic              load,
  input  logic              sys_clr,
  input  logic [WIDTH-1:0]  d,
  input  logic [WIDTH-1:0]  limit,
  input  logic [STEP_W-1:0] step,
  output logic [WIDTH-1:0]  q,
  output logic              max_tick,
  output logic              min_tick,
  output logic              wrap_pulse,
  output logic              sat_pulse
);

  localparam logic [WIDTH:0] ONE_X = (WIDTH+1)'(1);

  if (WIDTH < 2 || STEP_W > WIDTH || PRESCALE < 1) begin : g_bad_params
    $error("universal_modulo_counter: illegal parameter combination");
  end

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic             r_sat;

  logic [WIDTH-1:0] w_step_ext;
  logic [WIDTH-1:0] w_s;
  logic [WIDTH:0]   w_q_x;
  logic [WIDTH:0]   w_s_x;
  logic [WIDTH:0]   w_lim_x;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_up_wrap;
  logic [WIDTH-1:0] w_dn_wrap;
  logic             w_count;
  logic [WIDTH-1:0] w_q_next;
  logic             w_wrap_next;
  logic             w_sat_next;

  // Clamping the step to limit guarantees one subtraction/addition of (limit+1) lands in range.
  assign w_step_ext = WIDTH'(step);
  assign w_s        = (w_step_ext > limit) ? limit : w_step_ext;
  assign w_q_x      = {1'b0, r_q};
  assign w_s_x      = {1'b0, w_s};
  assign w_lim_x    = {1'b0, limit};
  assign w_sum      = w_q_x + w_s_x;
  assign w_up_wrap  = WIDTH'(w_sum - (w_lim_x + ONE_X));
  assign w_dn_wrap  = WIDTH'(w_q_x + w_lim_x + ONE_X - w_s_x);

`ifdef UMC_PRESCALE_EN
  localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] r_ps;

  assign w_count = en && (r_ps == PS_LAST);

  // Prescaler advances only on enabled cycles, so dropping en pauses it in place.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                r_ps <= '0;
    else if (sys_clr || load) r_ps <= '0;
    else if (en)              r_ps <= (r_ps == PS_LAST) ? '0 : r_ps + 1'b1;
  end
`else
  assign w_count = en;
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    w_q_next    = r_q;
    w_wrap_next = 1'b0;
    w_sat_next  = 1'b0;
    if (sys_clr) begin
      w_q_next = '0;
    end else if (load) begin
      w_q_next = (d > limit) ? limit : d;
    end else if (r_q > limit) begin
      w_q_next = limit;
    end else if (w_count && (w_s != '0)) begin
      if (up) begin
        if (w_sum <= w_lim_x) begin
          w_q_next = w_sum[WIDTH-1:0];
        end else if (sat) begin
          w_q_next   = limit;
          w_sat_next = 1'b1;
        end else begin
          w_q_next    = w_up_wrap;
          w_wrap_next = 1'b1;
        end
      end else begin
        if (w_s <= r_q) begin
          w_q_next = r_q - w_s;
        end else if (sat) begin
          w_q_next   = '0;
          w_sat_next = 1'b1;
        end else begin
          w_q_next    = w_dn_wrap;
          w_wrap_next = 1'b1;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
      r_sat  <= 1'b0;
    end else begin
      r_q    <= w_q_next;
      r_wrap <= w_wrap_next;
      r_sat  <= w_sat_next;
    end
  end

  assign q          = r_q;
  assign wrap_pulse = r_wrap;
  assign sat_pulse  = r_sat;
  assign max_tick   = (r_q == limit);
  assign min_tick   = (r_q == '0);

endmodule

// File: doc/universal_modulo_counter.md
Name: universal_modulo_counter

Overview:
- Parametrised successor to the team's fixed-width up/down counter.
- Adds a programmable modulus (runtime limit), a programmable step size, and a wrap/saturate mode select.
- Adds registered one-cycle boundary-event pulses.
- Used as a general timebase/event counter in datapath and control blocks: cascadable tick sources, address walkers, timeouts.

Parameters:
- WIDTH, 8, counter/limit/load width in bits (>=2).
- STEP_W, 4, width of the step input (STEP_W <= WIDTH).
- PRESCALE, 4, prescaler divide ratio (>=1); only used when UMC_PRESCALE_EN is defined.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  count enable.
- up  input  1  direction: 1 = up, 0 = down.
- sat  input  1  boundary mode: 1 = saturate, 0 = wrap.
- load  input  1  synchronous load of d.
- sys_clr  input  1  synchronous clear.
- d  input  WIDTH  load value.
- limit  input  WIDTH  inclusive upper bound; count range is [0, limit].
- step  input  STEP_W  increment/decrement magnitude.
- q  output  WIDTH  current count (registered).
- max_tick  output  1  combinational, q == limit.
- min_tick  output  1  combinational, q == 0.
- wrap_pulse  output  1  registered; high for 1 cycle when a wrap occurred.
- sat_pulse  output  1  registered; high for 1 cycle when a saturation clamp occurred.

Behaviour:
- Reset (asynchronous, any time, including mid-count): q=0, wrap_pulse=0, sat_pulse=0, prescaler=0.
- limit and step are sampled every cycle; they are not latched.
- Next-state priority each cycle, highest first:
  - sys_clr: q=0.
  - load: q = (d > limit) ? limit : d.
  - Out of range: if q > limit (limit lowered at runtime), q=limit regardless of en. No pulses.
  - Count: en (and prescaler terminal, if compiled in) causes a count.
  - Otherwise hold.
- Effective step: s = (step > limit) ? limit : step, zero-extended to WIDTH.
  - s == 0 (includes limit == 0): count cycle leaves q unchanged, no pulses.
- Up count, arithmetic in WIDTH+1 bits:
  - If q + s <= limit: q = q + s.
  - Else, wrap mode: q = q + s - (limit + 1), wrap_pulse=1 next cycle.
  - Else, saturate mode: q = limit. sat_pulse=1 only if q != limit beforehand or s > 0.
- Down count:
  - If s <= q: q = q - s.
  - Else, wrap mode: q = q + (limit + 1) - s, wrap_pulse=1.
  - Else, saturate mode: q = 0, sat_pulse=1.
- Because s <= limit, a single wrap always lands inside [0, limit]. No modulo divider is needed.
- wrap_pulse and sat_pulse:
  - Registered; they assert in the same cycle the new q becomes visible and are high exactly 1 cycle.
  - Never both high at once.
  - Forced to 0 in any cycle where sys_clr, load or the out-of-range clamp wins.
- max_tick and min_tick are both high when limit == 0 and q == 0.
- Full-scale case: limit = 2^WIDTH-1 gives plain modulo-2^WIDTH behaviour with step s.
- Latency: 1 clock from the sampled control inputs to the q update.

Optional Feature:
- Macro: UMC_PRESCALE_EN.
- Defined:
  - Adds an internal prescaler of ceil(log2(PRESCALE)) bits that counts only in cycles where en=1.
  - The main counter steps only on the en-cycle where the prescaler equals PRESCALE-1; the prescaler then returns to 0.
  - sys_clr, load and reset clear the prescaler.
  - PRESCALE=1 behaves identically to the macro being undefined.
- Undefined:
  - No prescaler logic; every en cycle is a count cycle.
  - The PRESCALE parameter is ignored.

Test Plan:
- WIDTH=8, limit=9, step=3, up=1, sat=0, en=1 from q=0 -> q sequence 3,6,9,2,5. wrap_pulse high only in the cycle q=2.
- limit=9, step=4, up=0, sat=1 from load d=6 -> q: 6,2,0,0. sat_pulse high in the cycle q first becomes 0; high again on the next count cycle only if s>0 and q was 0 (clamp). max_tick=0 and min_tick=1 while q=0.
- q=200, limit=255; drive limit=50 with en=0 -> q=50 next cycle, no pulses. Then load d=80 -> q=50 (clamped).
- sys_clr and load asserted together with en=1, d=7 -> q=0, pulses 0. Then assert reset asynchronously mid-cycle while counting -> q=0 immediately, without waiting for a clock edge.
- limit=0, step=5, en=1, both directions -> q stays 0, max_tick=min_tick=1, no pulses. Then step=0, limit=9 -> q holds.
- With UMC_PRESCALE_EN, PRESCALE=4, limit=255, step=1, en=1 for 12 cycles -> q increments 3 times. Toggling en low pauses the prescaler without losing its count.
